// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int STARVE_W = 4;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request/response bus between the two sources and the register file.
// Optional read-bypass signals are present when RF_WB_BYPASS_EN is defined.
interface rf_wb_arbiter_if;
    import rf_wb_pkg::*;

    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;
    logic            rf_we;
    logic [AW-1:0]   rf_wR;
    logic [XLEN-1:0] rf_wD;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]   rR1;
    logic [AW-1:0]   rR2;
    logic [XLEN-1:0] rf_rD1;
    logic [XLEN-1:0] rf_rD2;
    logic [XLEN-1:0] rD1;
    logic [XLEN-1:0] rD2;
`endif

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_we, rf_wR, rf_wD
`ifdef RF_WB_BYPASS_EN
        , output rR1, rR2, rf_rD1, rf_rD2
        , input  rD1, rD2
`endif
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_we, rf_wR, rf_wD
`ifdef RF_WB_BYPASS_EN
        , input  rR1, rR2, rf_rD1, rf_rD2
        , output rD1, rD2
`endif
    );

endinterface

// File: rtl/rf_wb_starve_ctr.sv
// Saturating count of consecutive stalled B cycles; asserts force_b at the limit.
module rf_wb_starve_ctr
    import rf_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                b_valid,
    input  logic                b_ready,
    output logic [STARVE_W-1:0] cnt,
    output logic                force_b
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    assign force_b = (cnt == LIMIT);

    // Any cycle that is not a stalled B request (B accepted or B idle) clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (b_valid && !b_ready) begin
            if (cnt != LIMIT) begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Fixed-priority (A over B) register-file write-port arbiter with starvation override.
// Define RF_WB_BYPASS_EN to add read-port forwarding of the staged write.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);

    logic                force_b;
    logic [STARVE_W-1:0] starve_cnt;
    grant_e              grant;
    wb_req_t             win;

    assign bus.a_ready = !force_b;
    assign bus.b_ready = force_b | !bus.a_valid;

    // The ready equations make A and B transfers mutually exclusive.
    always_comb begin
        grant = GNT_NONE;
        win   = '0;
        if (bus.a_valid && bus.a_ready) begin
            grant     = GNT_A;
            win.addr  = bus.a_addr;
            win.data  = bus.a_data;
        end else if (bus.b_valid && bus.b_ready) begin
            grant     = GNT_B;
            win.addr  = bus.b_addr;
            win.data  = bus.b_data;
        end
    end

    rf_wb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .b_valid (bus.b_valid),
        .b_ready (bus.b_ready),
        .cnt     (starve_cnt),
        .force_b (force_b)
    );

    // x0 writes complete the handshake but never reach the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rf_we <= 1'b0;
            bus.rf_wR <= '0;
            bus.rf_wD <= '0;
        end else begin
            bus.rf_we <= (grant != GNT_NONE) && (win.addr != '0);
            if ((grant != GNT_NONE) && (win.addr != '0)) begin
                bus.rf_wR <= win.addr;
                bus.rf_wD <= win.data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign bus.rD1 = (bus.rf_we && bus.rf_wR == bus.rR1 && bus.rR1 != '0) ? bus.rf_wD : bus.rf_rD1;
    assign bus.rD2 = (bus.rf_we && bus.rf_wR == bus.rR2 && bus.rR2 != '0) ? bus.rf_wD : bus.rf_rD2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT = 4).
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
`ifdef RF_WB_BYPASS_EN
        bus.rR1    = '0;
        bus.rR2    = '0;
        bus.rf_rD1 = '0;
        bus.rf_rD2 = '0;
`endif
        edge_step();
        edge_step();
        chk("rst_we", 64'(bus.rf_we), 64'd0);
        chk("rst_wR", 64'(bus.rf_wR), 64'd0);
        chk("rst_wD", 64'(bus.rf_wD), 64'd0);
        chk("rst_cnt", 64'(dut.u_starve.cnt), 64'd0);
        rst = 1'b0;
        edge_step();

        // A only
        bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
        #1;
        chk("a_only_ready", 64'(bus.a_ready), 64'd1);
        edge_step();
        chk("a_only_we", 64'(bus.rf_we), 64'd1);
        chk("a_only_wR", 64'(bus.rf_wR), 64'd5);
        chk("a_only_wD", 64'(bus.rf_wD), 64'hDEADBEEF);
        bus.a_valid = 1'b0;
        edge_step();
        chk("a_only_we_off", 64'(bus.rf_we), 64'd0);
        chk("a_only_wR_hold", 64'(bus.rf_wR), 64'd5);
        chk("a_only_wD_hold", 64'(bus.rf_wD), 64'hDEADBEEF);

        // Back-to-back A writes to r3
        bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'd1;
        edge_step();
        chk("b2b_we1", 64'(bus.rf_we), 64'd1);
        chk("b2b_wR1", 64'(bus.rf_wR), 64'd3);
        chk("b2b_wD1", 64'(bus.rf_wD), 64'd1);
        bus.a_data = 32'd2;
        edge_step();
        chk("b2b_we2", 64'(bus.rf_we), 64'd1);
        chk("b2b_wD2", 64'(bus.rf_wD), 64'd2);
        bus.a_valid = 1'b0;
        edge_step();
        chk("b2b_we_off", 64'(bus.rf_we), 64'd0);

        // Starvation: A and B both valid
        bus.a_valid = 1'b1; bus.a_addr = 5'd1; bus.a_data = 32'hA0A0A0A0;
        bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'hB0B0B0B0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_cnt", 64'(dut.u_starve.cnt), 64'(i));
            chk("starve_b_ready", 64'(bus.b_ready), 64'd0);
            chk("starve_a_ready", 64'(bus.a_ready), 64'd1);
            edge_step();
            chk("starve_a_wR", 64'(bus.rf_wR), 64'd1);
            chk("starve_a_wD", 64'(bus.rf_wD), 64'hA0A0A0A0);
        end
        #1;
        chk("force_cnt", 64'(dut.u_starve.cnt), 64'd4);
        chk("force_b_ready", 64'(bus.b_ready), 64'd1);
        chk("force_a_ready", 64'(bus.a_ready), 64'd0);
        edge_step();
        bus.b_valid = 1'b0;
        chk("force_we", 64'(bus.rf_we), 64'd1);
        chk("force_wR", 64'(bus.rf_wR), 64'd9);
        chk("force_wD", 64'(bus.rf_wD), 64'hB0B0B0B0);
        chk("force_cnt_clr", 64'(dut.u_starve.cnt), 64'd0);
        #1;
        chk("after_force_a_ready", 64'(bus.a_ready), 64'd1);
        edge_step();
        chk("after_force_wR", 64'(bus.rf_wR), 64'd1);

        // Forced cycle where B illegally drops its request
        bus.b_valid = 1'b1;
        repeat (4) edge_step();
        chk("drop_cnt", 64'(dut.u_starve.cnt), 64'd4);
        bus.b_valid = 1'b0;
        #1;
        chk("drop_a_ready", 64'(bus.a_ready), 64'd0);
        chk("drop_b_ready", 64'(bus.b_ready), 64'd1);
        edge_step();
        chk("drop_we", 64'(bus.rf_we), 64'd0);
        chk("drop_cnt_clr", 64'(dut.u_starve.cnt), 64'd0);
        bus.a_valid = 1'b0;
        edge_step();

        // x0 write from B
        bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h12345678;
        #1;
        chk("x0_b_ready", 64'(bus.b_ready), 64'd1);
        edge_step();
        bus.b_valid = 1'b0;
        chk("x0_we", 64'(bus.rf_we), 64'd0);
        chk("x0_cnt", 64'(dut.u_starve.cnt), 64'd0);
        edge_step();

`ifdef RF_WB_BYPASS_EN
        bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h55;
        edge_step();
        bus.a_valid = 1'b0;
        bus.rR1 = 5'd7; bus.rf_rD1 = 32'h11;
        bus.rR2 = 5'd8; bus.rf_rD2 = 32'h22;
        #1;
        chk("byp_rD1_fwd", 64'(bus.rD1), 64'h55);
        chk("byp_rD2_raw", 64'(bus.rD2), 64'h22);
        bus.rR1 = 5'd0;
        #1;
        chk("byp_rD1_x0", 64'(bus.rD1), 64'h11);
        edge_step();
`endif

        // Reset mid-transfer drops the staged write
        bus.a_valid = 1'b1; bus.a_addr = 5'd6; bus.a_data = 32'hCAFEF00D;
        edge_step();
        chk("pre_rst_we", 64'(bus.rf_we), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 64'(bus.rf_we), 64'd0);
        chk("mid_rst_wR", 64'(bus.rf_wR), 64'd0);
        chk("mid_rst_wD", 64'(bus.rf_wD), 64'd0);
        edge_step();
        chk("rst_hold_we", 64'(bus.rf_we), 64'd0);
        rst = 1'b0;
        bus.a_valid = 1'b0;
        edge_step();
        chk("post_rst_we", 64'(bus.rf_we), 64'd0);
        chk("post_rst_wR", 64'(bus.rf_wR), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
